// File: rtl/conv1_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv1_window_scheduler
// Brief    : Two-line-buffer cross-window sequencer feeding Conv1, with
//            latency-matched result tagging and a start/busy/done frame handshake.
// Revision : 1.0
// ============================================================================
module conv1_window_scheduler #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int PIPE_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic [3:0]               pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic [3:0]               conv_in1,
    output logic [3:0]               conv_in2,
    output logic [3:0]               conv_in3,
    output logic [3:0]               conv_in4,
    output logic [3:0]               conv_in5,
    output logic                     conv_valid,
    input  logic [7:0]               conv_result,
    output logic [7:0]               res_data,
    output logic                     res_valid,
    output logic [$clog2(IMG_H)-1:0] res_row,
    output logic [$clog2(IMG_W)-1:0] res_col
);
    localparam int c_RW = $clog2(IMG_H);
    localparam int c_CW = $clog2(IMG_W);
    localparam int c_DW = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_RW-1:0]   r_row;
    logic [c_CW-1:0]   r_col;
    logic [c_DW-1:0]   r_drainCnt;

    // rLineA holds row r-1, rLineB holds row r-2 (indexed by column)
    logic [3:0]        r_lineA [IMG_W];
    logic [3:0]        r_lineB [IMG_W];
    logic [3:0]        r_topD;
    logic [3:0]        r_midD1;
    logic [3:0]        r_midD2;
    logic [3:0]        r_botD;
    logic [c_RW-1:0]   r_tagRow;
    logic [c_CW-1:0]   r_tagCol;

    logic              r_vPipe   [PIPE_LAT];
    logic [c_RW-1:0]   r_rowPipe [PIPE_LAT];
    logic [c_CW-1:0]   r_colPipe [PIPE_LAT];

    logic              w_accept;
    logic              w_lastCol;
    logic              w_lastRow;
    logic              w_interior;
    logic [3:0]        w_lineA;
    logic [3:0]        w_lineB;

    assign w_accept   = pix_valid && pix_ready;
    assign w_lastCol  = (r_col == c_CW'(IMG_W - 1));
    assign w_lastRow  = (r_row == c_RW'(IMG_H - 1));
    assign w_interior = (r_row >= c_RW'(2)) && (r_col >= c_CW'(2));
    assign w_lineA    = r_lineA[r_col];
    assign w_lineB    = r_lineB[r_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pix_ready  <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_drainCnt <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FILL;
                        busy      <= 1'b1;
                        pix_ready <= 1'b1;
                        r_row     <= '0;
                        r_col     <= '0;
                    end
                end
                S_FILL: begin
                    if (w_accept && w_lastCol && (r_row == c_RW'(1))) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept && w_lastCol && w_lastRow) begin
                        r_state    <= S_DRAIN;
                        pix_ready  <= 1'b0;
                        r_drainCnt <= '0;
                    end
                end
                // Held one cycle beyond PIPE_LAT so done lands just after the last result.
                S_DRAIN: begin
                    if (r_drainCnt == c_DW'(PIPE_LAT)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_drainCnt <= r_drainCnt + c_DW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_accept) begin
                if (w_lastCol) begin
                    r_col <= '0;
                    r_row <= r_row + c_RW'(1);
                end else begin
                    r_col <= r_col + c_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lineA[r_col] <= pix_in;
            r_lineB[r_col] <= w_lineA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_topD     <= '0;
            r_midD1    <= '0;
            r_midD2    <= '0;
            r_botD     <= '0;
            conv_in1   <= '0;
            conv_in2   <= '0;
            conv_in3   <= '0;
            conv_in4   <= '0;
            conv_in5   <= '0;
            conv_valid <= 1'b0;
            r_tagRow   <= '0;
            r_tagCol   <= '0;
        end else begin
            conv_valid <= 1'b0;
            if (w_accept) begin
                r_topD  <= w_lineB;
                r_midD1 <= w_lineA;
                r_midD2 <= r_midD1;
                r_botD  <= pix_in;
                if (w_interior) begin
                    conv_in1   <= r_topD;
                    conv_in2   <= r_midD2;
                    conv_in3   <= r_midD1;
                    conv_in4   <= w_lineA;
                    conv_in5   <= r_botD;
                    conv_valid <= 1'b1;
                    r_tagRow   <= r_row - c_RW'(1);
                    r_tagCol   <= r_col - c_CW'(1);
                end
            end
        end
    end

    // Tag pipeline runs in lockstep with Conv1, which never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_vPipe[i]   <= 1'b0;
                r_rowPipe[i] <= '0;
                r_colPipe[i] <= '0;
            end
        end else begin
            r_vPipe[0]   <= conv_valid;
            r_rowPipe[0] <= r_tagRow;
            r_colPipe[0] <= r_tagCol;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_vPipe[i]   <= r_vPipe[i-1];
                r_rowPipe[i] <= r_rowPipe[i-1];
                r_colPipe[i] <= r_colPipe[i-1];
            end
        end
    end

    assign res_valid = r_vPipe[PIPE_LAT-1];
    assign res_row   = r_rowPipe[PIPE_LAT-1];
    assign res_col   = r_colPipe[PIPE_LAT-1];
    assign res_data  = conv_result;

endmodule
`default_nettype wire
